// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU plus iterative multiply/divide writing HI/LO.
// Divider hardware exists only when ALU_MULDIV_DIVIDER_EN is defined; otherwise DIV/DIVU act as illegal ops.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL = 2'd1;
`ifdef ALU_MULDIV_DIVIDER_EN
  localparam logic [1:0] DIV = 2'd2;
`endif
  logic [1:0] state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, fin;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic [WIDTH-1:0] alu_r, add_r, sub_r, am, bm;
  logic [WIDTH:0] sum;
  logic qneg_q, qneg_d, out_valid_q, out_valid_d, overflow_q, overflow_d;
  logic alu_ov, mul_op, div_op, accept;
`ifdef ALU_MULDIV_DIVIDER_EN
  logic rneg_q, rneg_d, ge;
  logic [WIDTH:0] r;
  logic [WIDTH-1:0] dif;
  assign div_op = op[4:1] == 4'b1001;
`else
  assign div_op = 1'b0;
`endif
  assign mul_op = op[4:1] == 4'b1000;
  assign accept = in_valid && in_ready;
  assign in_ready = !rst && state_q == IDLE && (!out_valid_q || out_ready);
  assign busy = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign overflow = overflow_q;
  assign hi = hi_q;
  assign lo = lo_q;
  // Signed MDU ops (even codes) iterate on magnitudes; signs are restored on completion.
  assign am = (!op[0] && a[WIDTH-1]) ? -a : a;
  assign bm = (!op[0] && b[WIDTH-1]) ? -b : b;
  always_comb begin
    add_r = a + b;
    sub_r = a - b;
    alu_ov = (op == 5'd0 && a[WIDTH-1] == b[WIDTH-1] && add_r[WIDTH-1] != a[WIDTH-1]) ||
             (op == 5'd2 && a[WIDTH-1] != b[WIDTH-1] && sub_r[WIDTH-1] != a[WIDTH-1]);
    case (op)
      5'd0, 5'd1: alu_r = add_r;
      5'd2, 5'd3: alu_r = sub_r;
      5'd4:       alu_r = a & b;
      5'd5:       alu_r = a | b;
      5'd6:       alu_r = a ^ b;
      5'd7:       alu_r = ~(a | b);
      5'd8:       alu_r = b << a[SHW-1:0];
      5'd9:       alu_r = b >> a[SHW-1:0];
      5'd10:      alu_r = $signed(b) >>> a[SHW-1:0];
      5'd11:      alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      5'd12:      alu_r = {{(WIDTH-1){1'b0}}, a < b};
      5'd13:      alu_r = b << (WIDTH / 2);
      5'd20:      alu_r = hi_q;
      5'd21:      alu_r = lo_q;
      5'd22, 5'd23: alu_r = a;
      default:    alu_r = '0;
    endcase
  end
  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    step = {sum, acc_q[WIDTH-1:1]};
    fin = qneg_q ? -step : step;
`ifdef ALU_MULDIV_DIVIDER_EN
    r = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge = r >= {1'b0, m_q};
    dif = r[WIDTH-1:0] - m_q;
    if (state_q == DIV) begin
      step = {ge ? dif : r[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
      fin = {rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH],
             qneg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]};
    end
`endif
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    m_d = m_q;
    qneg_d = qneg_q;
`ifdef ALU_MULDIV_DIVIDER_EN
    rneg_d = rneg_q;
`endif
    hi_d = hi_q;
    lo_d = lo_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d = result_q;
    overflow_d = overflow_q;
    if (accept) begin
      if (mul_op || div_op) begin
        state_d = MUL;
        cnt_d = '0;
        acc_d = {{WIDTH{1'b0}}, mul_op ? bm : am};
        m_d = mul_op ? am : bm;
        // A zero divisor must leave the all-ones quotient un-negated.
        qneg_d = !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]) && (mul_op || |b);
`ifdef ALU_MULDIV_DIVIDER_EN
        if (div_op) state_d = DIV;
        rneg_d = !op[0] && a[WIDTH-1];
`endif
      end else begin
        out_valid_d = 1'b1;
        result_d = alu_r;
        overflow_d = alu_ov;
        hi_d = op == 5'd22 ? a : hi_q;
        lo_d = op == 5'd23 ? a : lo_q;
      end
    end else if (state_q != IDLE) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == SHW'(WIDTH - 1)) begin
        state_d = IDLE;
        {hi_d, lo_d} = fin;
        out_valid_d = 1'b1;
        result_d = fin[WIDTH-1:0];
        overflow_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      m_q <= '0;
      qneg_q <= 1'b0;
`ifdef ALU_MULDIV_DIVIDER_EN
      rneg_q <= 1'b0;
`endif
      hi_q <= '0;
      lo_q <= '0;
      out_valid_q <= 1'b0;
      result_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      m_q <= m_d;
      qneg_q <= qneg_d;
`ifdef ALU_MULDIV_DIVIDER_EN
      rneg_q <= rneg_d;
`endif
      hi_q <= hi_d;
      lo_q <= lo_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
- REQ-001: Parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
- REQ-002: Parameter SHW, default $clog2(WIDTH), shift-amount width.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset; asynchronous, active-high.
- REQ-005: in_valid  input  1  operation request.
- REQ-006: in_ready  output  1  block accepts a request this cycle.
- REQ-007: op  input  5  operation code; see REQ-013.
- REQ-008: a  input  WIDTH  operand A; also the shift amount for shift ops.
- REQ-009: b  input  WIDTH  operand B; also the shifted value for shift ops.
- REQ-010: out_valid, result[WIDTH], overflow[1]  outputs  result handshake, data, signed-overflow flag.
- REQ-011: out_ready  input  1  consumer accepts the result.
- REQ-012: hi, lo  output  WIDTH each  architectural HI/LO registers; busy  output  1  high while multiply or divide is iterating.

Function
- REQ-013: op encoding: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLL, 9 SRL, 10 SRA, 11 SLT, 12 SLTU, 13 LUI (b<<WIDTH/2), 16 MULT, 17 MULTU, 18 DIV, 19 DIVU, 20 MFHI, 21 MFLO, 22 MTHI (a), 23 MTLO (a); all other codes are illegal.
- REQ-014: Accept occurs when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
- REQ-015: FSM states IDLE, MUL, DIV; IDLE->MUL on accepting 16/17; IDLE->DIV on accepting 18/19; MUL/DIV->IDLE when the iteration counter reaches WIDTH-1.
- REQ-016: Single-cycle ops (0-13, 20-23, illegal) set out_valid and result on the edge after accept, giving latency 1.
- REQ-017: Shifts use only a[SHW-1:0]; SRA sign-fills from b[WIDTH-1]; SLT/SLTU return 1 or 0 zero-extended.
- REQ-018: overflow is set only for ADD/SUB signed overflow; result still holds the wrapped sum; overflow is 0 for every other op.
- REQ-019: MULT/MULTU run as an iterative shift-add of WIDTH iterations; {hi,lo} receives the 2*WIDTH-bit product; out_valid rises exactly WIDTH+1 cycles after accept, with result = new lo.
- REQ-020: DIV/DIVU run as an iterative restoring divide of WIDTH iterations with the same latency; lo gets the quotient and hi the remainder.
- REQ-021: Signed divide truncates toward zero, and the remainder takes the dividend's sign.
- REQ-022: Most-negative / -1 gives lo = most-negative, hi = 0.
- REQ-023: Divide by zero completes at normal latency with lo = all ones and hi = a; it never hangs.
- REQ-024: MTHI/MTLO write hi/lo on the accept edge and produce result = a.
- REQ-025: hi/lo are unchanged during iteration and update only on the completion edge.
- REQ-026: out_valid, result and overflow hold stable while out_valid && !out_ready.
- REQ-027: out_valid clears on out_ready unless a new result is produced on the same edge.
- REQ-028: Illegal op gives result 0 and overflow 0, with hi/lo unchanged and latency 1.
- REQ-029: busy = (state != IDLE).

Reset
- REQ-030: rst asserted forces IDLE and sets out_valid, result, overflow, hi, lo, busy and the iteration counter to 0 immediately.
- REQ-031: Reset during MUL/DIV aborts the operation with no partial hi/lo write.
- REQ-032: in_ready is 0 while rst is high.

Configuration
- REQ-033: Macro ALU_MULDIV_DIVIDER_EN defined: DIV/DIVU behave per REQ-020 to REQ-023.
- REQ-034: Macro ALU_MULDIV_DIVIDER_EN undefined: no divider logic exists, and DIV/DIVU are treated as illegal ops per REQ-028; the DIV state is unreachable.

Verification (WIDTH=32)
- REQ-035: Bench drives ADD a=0x7FFFFFFF, b=1, with out_ready=1. Next cycle requires result=0x80000000, overflow=1, out_valid=1.
- REQ-036: Bench drives MULT a=0xFFFFFFFE (-2), b=3. Requires out_valid exactly 33 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy high for 32 cycles, and in_ready low throughout.
- REQ-037: Bench drives DIV a=-7, b=2, then DIVU a=5, b=0. Requires lo=0xFFFFFFFD, hi=0xFFFFFFFF, then lo=0xFFFFFFFF, hi=5, each at latency 33.
- REQ-038: Bench holds out_ready=0 for 5 cycles after an SRA a=4, b=0x80000000 result. Requires result=0xF8000000 held stable, in_ready=0, and no second accept until out_ready=1.
- REQ-039: Bench asserts rst mid-DIVU at iteration 10. Requires out_valid=0, hi=lo=0, busy=0 immediately, and an ADD accepted the first cycle after rst drops.
- REQ-040: Bench builds with ALU_MULDIV_DIVIDER_EN undefined and drives DIV a=9, b=3. Requires result=0 at latency 1 with hi/lo unchanged.
